// File: rtl/controlador_acesso_rr_if.sv
// -----------------------------------------------------------------------------
// controlador_acesso_rr_if
// Bundle of the station request bus and the terminal grant/display outputs of
// the round-robin access controller.
//
// Handshake: a station asserts req[i] and holds id/func/term while it wants its
// terminal. The one-hot gnt_* bit is the acknowledgement. The grant lasts until
// the station drops req[i] or the hold budget runs out. A refused request is
// flagged on deny[i] and never granted. There is no separate ready signal.
//
// Signals:
//   req        station -> ctrl  request per station
//   id_in      station -> ctrl  station i ID at [i*ID_W +: ID_W]
//   func_in    station -> ctrl  station i function at [i*3 +: 3], 0 = none
//   term_in    station -> ctrl  target terminal, 0 = matrix, 1 = LEDs
//   gnt_matriz ctrl -> station  one-hot matrix owner
//   gnt_leds   ctrl -> station  one-hot LED owner
//   fmatriz    ctrl -> decoder  function code for the matrix
//   fleds      ctrl -> decoder  function code for the LEDs
//   busy_*     ctrl -> system   terminal currently granted
//   deny       ctrl -> station  request refused by permission
//   disp_id    ctrl -> display  ID of the most recent grant
//   disp_valid ctrl -> display  disp_id is meaningful
// Modports: master = station/system side, slave = controller side.
// -----------------------------------------------------------------------------
interface controlador_acesso_rr_if #(
  parameter int N_USERS = 2,
  parameter int ID_W    = 3
);
  logic [N_USERS-1:0]      req;
  logic [N_USERS*ID_W-1:0] id_in;
  logic [N_USERS*3-1:0]    func_in;
  logic [N_USERS-1:0]      term_in;
  logic [N_USERS-1:0]      gnt_matriz;
  logic [N_USERS-1:0]      gnt_leds;
  logic [2:0]              fmatriz;
  logic [2:0]              fleds;
  logic                    busy_matriz;
  logic                    busy_leds;
  logic [N_USERS-1:0]      deny;
  logic [ID_W-1:0]         disp_id;
  logic                    disp_valid;

  modport master (
    output req, id_in, func_in, term_in,
    input  gnt_matriz, gnt_leds, fmatriz, fleds, busy_matriz, busy_leds,
           deny, disp_id, disp_valid
  );

  modport slave (
    input  req, id_in, func_in, term_in,
    output gnt_matriz, gnt_leds, fmatriz, fleds, busy_matriz, busy_leds,
           deny, disp_id, disp_valid
  );
endinterface

// File: rtl/controlador_acesso_rr.sv
// -----------------------------------------------------------------------------
// controlador_acesso_rr
// Access controller for N_USERS stations sharing two terminals (index 0 =
// matrix, 1 = LEDs). Requests are registered, checked against PERM_MASK and
// arbitrated round-robin per terminal. A grant lasts at most HOLD_CYCLES
// cycles and is followed by exactly one idle cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus_if       controlador_acesso_rr_if.slave (requests in, grants out)
//   dbg_state_o  FSM state per terminal, bit t = 1 when terminal t is in GRANT
// -----------------------------------------------------------------------------
module controlador_acesso_rr #(
  parameter int N_USERS     = 2,
  parameter int ID_W        = 3,
  parameter int HOLD_CYCLES = 8,
  parameter logic [(2**ID_W)*8-1:0] PERM_MASK = 64'hFEFE_FEFE_FEFE_FE00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  controlador_acesso_rr_if.slave    bus_if,
  output logic [1:0]                dbg_state_o
);

  localparam int OW = $clog2(N_USERS);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  // Registered copies of the station bus; every decision uses these.
  logic [N_USERS-1:0]      req_q;
  logic [N_USERS*ID_W-1:0] id_q;
  logic [N_USERS*3-1:0]    func_q;
  logic [N_USERS-1:0]      term_q;

  logic [N_USERS-1:0] valid_req, perm_ok, deny_d, deny_q;
  logic [N_USERS-1:0] elig [2];

  // Per-terminal state, index 0 = matrix, 1 = LEDs.
  state_t             state_q [2], state_d [2];
  logic [OW-1:0]      owner_q [2], owner_d [2];
  logic [OW-1:0]      ptr_q   [2], ptr_d   [2];
  logic [CW-1:0]      cnt_q   [2], cnt_d   [2];
  logic [2:0]         code_q  [2], code_d  [2];
  logic [N_USERS-1:0] gnt_q   [2], gnt_d   [2];
  logic               found   [2];
  logic [OW-1:0]      pick    [2];
  logic               grant_now [2];

  logic [ID_W-1:0] disp_id_q, disp_id_d;
  logic            disp_valid_q, disp_valid_d;

  // Permission lookup: the mask bit index is {id, func} = id*8 + func.
  always_comb begin
    valid_req = '0;
    perm_ok   = '0;
    for (int i = 0; i < N_USERS; i++) begin
      valid_req[i] = req_q[i] && (func_q[i*3 +: 3] != 3'd0);
      perm_ok[i]   = PERM_MASK[{id_q[i*ID_W +: ID_W], func_q[i*3 +: 3]}];
    end
  end

  assign deny_d  = valid_req & ~perm_ok;
  assign elig[0] = valid_req & perm_ok & ~term_q;
  assign elig[1] = valid_req & perm_ok &  term_q;

  // Round-robin pick: scanning offsets from high to low lets the smallest
  // offset from the pointer overwrite the others.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      found[t] = 1'b0;
      pick[t]  = '0;
      for (int j = N_USERS - 1; j >= 0; j--) begin
        if (elig[t][(int'(ptr_q[t]) + j) % N_USERS]) begin
          found[t] = 1'b1;
          pick[t]  = OW'((int'(ptr_q[t]) + j) % N_USERS);
        end
      end
    end
  end

  // Terminal FSMs: next state and registered outputs.
  always_comb begin
    for (int t = 0; t < 2; t++) begin
      state_d[t]   = state_q[t];
      owner_d[t]   = owner_q[t];
      ptr_d[t]     = ptr_q[t];
      cnt_d[t]     = cnt_q[t];
      code_d[t]    = code_q[t];
      gnt_d[t]     = gnt_q[t];
      grant_now[t] = 1'b0;
      case (state_q[t])
        S_IDLE: begin
          if (found[t]) begin
            state_d[t]   = S_GRANT;
            owner_d[t]   = pick[t];
            code_d[t]    = func_q[pick[t]*3 +: 3];
            cnt_d[t]     = CNT_LOAD;
            ptr_d[t]     = OW'((int'(pick[t]) + 1) % N_USERS);
            gnt_d[t]     = N_USERS'(1) << pick[t];
            grant_now[t] = 1'b1;
          end
        end
        S_GRANT: begin
          // Owner fields are latched; only its live req can end the grant early.
          if (!req_q[owner_q[t]] || (cnt_q[t] == '0)) begin
            state_d[t] = S_IDLE;
            gnt_d[t]   = '0;
            code_d[t]  = 3'd0;
          end else begin
            cnt_d[t] = cnt_q[t] - CW'(1);
          end
        end
        default: state_d[t] = S_IDLE;
      endcase
    end
  end

  // Display follows the latest grant; the matrix wins a same-cycle tie.
  always_comb begin
    disp_id_d    = disp_id_q;
    disp_valid_d = disp_valid_q;
    if (grant_now[1]) begin
      disp_id_d    = id_q[pick[1]*ID_W +: ID_W];
      disp_valid_d = 1'b1;
    end
    if (grant_now[0]) begin
      disp_id_d    = id_q[pick[0]*ID_W +: ID_W];
      disp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      id_q         <= '0;
      func_q       <= '0;
      term_q       <= '0;
      deny_q       <= '0;
      disp_id_q    <= '0;
      disp_valid_q <= 1'b0;
      for (int t = 0; t < 2; t++) begin
        state_q[t] <= S_IDLE;
        owner_q[t] <= '0;
        ptr_q[t]   <= '0;
        cnt_q[t]   <= '0;
        code_q[t]  <= 3'd0;
        gnt_q[t]   <= '0;
      end
    end else begin
      req_q        <= bus_if.req;
      id_q         <= bus_if.id_in;
      func_q       <= bus_if.func_in;
      term_q       <= bus_if.term_in;
      deny_q       <= deny_d;
      disp_id_q    <= disp_id_d;
      disp_valid_q <= disp_valid_d;
      for (int t = 0; t < 2; t++) begin
        state_q[t] <= state_d[t];
        owner_q[t] <= owner_d[t];
        ptr_q[t]   <= ptr_d[t];
        cnt_q[t]   <= cnt_d[t];
        code_q[t]  <= code_d[t];
        gnt_q[t]   <= gnt_d[t];
      end
    end
  end

  assign bus_if.gnt_matriz  = gnt_q[0];
  assign bus_if.gnt_leds    = gnt_q[1];
  assign bus_if.fmatriz     = code_q[0];
  assign bus_if.fleds       = code_q[1];
  assign bus_if.busy_matriz = (state_q[0] == S_GRANT);
  assign bus_if.busy_leds   = (state_q[1] == S_GRANT);
  assign bus_if.deny        = deny_q;
  assign bus_if.disp_id     = disp_id_q;
  assign bus_if.disp_valid  = disp_valid_q;
  assign dbg_state_o        = {state_q[1] == S_GRANT, state_q[0] == S_GRANT};

endmodule

// File: tb/tb_controlador_acesso_rr.sv
// -----------------------------------------------------------------------------
// tb_controlador_acesso_rr
// Directed bench for controlador_acesso_rr. A behavioural model tracks, per
// terminal, who owns it and for how many cycles, and a compare process checks
// every output on each falling edge. Literal expectations pin the scenarios.
// -----------------------------------------------------------------------------
module tb_controlador_acesso_rr;
  localparam int N    = 2;
  localparam int ID_W = 3;
  localparam int HOLD = 8;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int n_chk;
  int n_err;

  controlador_acesso_rr_if #(.N_USERS(N), .ID_W(ID_W)) bus_if ();

  controlador_acesso_rr #(
    .N_USERS(N), .ID_W(ID_W), .HOLD_CYCLES(HOLD),
    .PERM_MASK(64'hFEFE_FEFE_FEFE_FE00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus_if), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [63:0]       perm_mask;
  logic [N-1:0]      s_req, s_term;
  logic [N*ID_W-1:0] s_id;
  logic [N*3-1:0]    s_func;
  int                m_owner [2];
  int                m_held  [2];
  int                m_ptr   [2];
  logic [2:0]        m_code  [2];
  logic [N-1:0]      m_deny;
  logic [ID_W-1:0]   m_disp;
  logic              m_valid;

  function automatic bit allowed(input int c);
    int id;
    int f;
    id = int'(s_id[c*ID_W +: ID_W]);
    f  = int'(s_func[c*3 +: 3]);
    return (f != 0) && perm_mask[id*8 + f];
  endfunction

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    s_req = '0; s_term = '0; s_id = '0; s_func = '0;
    m_deny = '0; m_disp = '0; m_valid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      m_owner[t] = -1; m_held[t] = 0; m_ptr[t] = 0; m_code[t] = 3'd0;
    end
  endtask

  task automatic model_step();
    bit disp_set;
    int c;
    disp_set = 1'b0;
    for (int i = 0; i < N; i++)
      m_deny[i] = s_req[i] && (s_func[i*3 +: 3] != 3'd0) && !allowed(i);
    for (int t = 0; t < 2; t++) begin
      if (m_owner[t] >= 0) begin
        if (!s_req[m_owner[t]] || m_held[t] == HOLD) begin
          m_owner[t] = -1;
          m_code[t]  = 3'd0;
        end else begin
          m_held[t] = m_held[t] + 1;
        end
      end else begin
        for (int j = 0; j < N; j++) begin
          c = (m_ptr[t] + j) % N;
          if (m_owner[t] < 0 && s_req[c] && allowed(c) && (int'(s_term[c]) == t)) begin
            m_owner[t] = c;
            m_held[t]  = 1;
            m_code[t]  = s_func[c*3 +: 3];
            m_ptr[t]   = (c + 1) % N;
            if (!disp_set) begin
              m_disp   = s_id[c*ID_W +: ID_W];
              m_valid  = 1'b1;
              disp_set = 1'b1;
            end
          end
        end
      end
    end
    s_req = bus_if.req; s_term = bus_if.term_in; s_id = bus_if.id_in; s_func = bus_if.func_in;
  endtask

  initial begin
    perm_mask = 64'hFEFE_FEFE_FEFE_FE00;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc gnt_matriz", 32'(bus_if.gnt_matriz), 32'(onehot(m_owner[0])));
      chk("cyc gnt_leds",   32'(bus_if.gnt_leds),   32'(onehot(m_owner[1])));
      chk("cyc fmatriz",    32'(bus_if.fmatriz),    32'(m_code[0]));
      chk("cyc fleds",      32'(bus_if.fleds),      32'(m_code[1]));
      chk("cyc busy_matriz", 32'(bus_if.busy_matriz), 32'(m_owner[0] >= 0));
      chk("cyc busy_leds",  32'(bus_if.busy_leds),  32'(m_owner[1] >= 0));
      chk("cyc deny",       32'(bus_if.deny),       32'(m_deny));
      chk("cyc disp_id",    32'(bus_if.disp_id),    32'(m_disp));
      chk("cyc disp_valid", 32'(bus_if.disp_valid), 32'(m_valid));
      chk("cyc dbg_state",  32'(dbg_state), 32'({m_owner[1] >= 0, m_owner[0] >= 0}));
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_st(input int i, input bit r, input int id, input int f, input bit term);
    bus_if.req[i]                  = r;
    bus_if.id_in[i*ID_W +: ID_W]   = ID_W'(id);
    bus_if.func_in[i*3 +: 3]       = 3'(f);
    bus_if.term_in[i]              = term;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt_matriz"}, 32'(bus_if.gnt_matriz), 0);
    chk({tag, " gnt_leds"},   32'(bus_if.gnt_leds), 0);
    chk({tag, " fmatriz"},    32'(bus_if.fmatriz), 0);
    chk({tag, " fleds"},      32'(bus_if.fleds), 0);
    chk({tag, " busy"},       32'({bus_if.busy_matriz, bus_if.busy_leds}), 0);
    chk({tag, " deny"},       32'(bus_if.deny), 0);
    chk({tag, " disp"},       32'({bus_if.disp_valid, bus_if.disp_id}), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_chk = 0;
    n_err = 0;
    bus_if.req = '0; bus_if.id_in = '0; bus_if.func_in = '0; bus_if.term_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset with random inputs, then release with REQ=0.
    repeat (4) begin
      @(posedge clk); #1;
      bus_if.req     = N'($urandom);
      bus_if.id_in   = (N*ID_W)'($urandom);
      bus_if.func_in = (N*3)'($urandom);
      bus_if.term_in = N'($urandom);
    end
    tick(1);
    chk_all_zero("in_reset");
    bus_if.req = '0; bus_if.id_in = '0; bus_if.func_in = '0; bus_if.term_in = '0;
    rst_n = 1'b1;
    tick(3);
    chk_all_zero("after_reset");

    // Permission deny: ID 0 has no functions.
    set_st(1, 1'b1, 0, 2, 1'b1);
    tick(1);
    chk("deny early", 32'(bus_if.deny), 0);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk("deny", 32'(bus_if.deny), 32'h2);
      chk("deny gnt", 32'({bus_if.gnt_leds, bus_if.gnt_matriz}), 0);
      chk("deny disp_valid", 32'(bus_if.disp_valid), 0);
      tick(1);
    end
    set_st(1, 1'b0, 0, 0, 1'b0);
    tick(2);
    chk("deny cleared", 32'(bus_if.deny), 0);

    // Single grant with timeout on the matrix.
    set_st(0, 1'b1, 3, 5, 1'b0);
    tick(1);
    chk("single latency", 32'(bus_if.gnt_matriz), 0);
    tick(1);
    chk("single fmatriz", 32'(bus_if.fmatriz), 5);
    chk("single busy", 32'(bus_if.busy_matriz), 1);
    chk("single disp_id", 32'(bus_if.disp_id), 3);
    chk("single disp_valid", 32'(bus_if.disp_valid), 1);
    for (int i = 0; i < HOLD; i++) begin
      chk("single hold", 32'(bus_if.gnt_matriz), 32'h1);
      tick(1);
    end
    chk("single idle gnt", 32'(bus_if.gnt_matriz), 0);
    chk("single idle code", 32'(bus_if.fmatriz), 0);
    chk("single idle busy", 32'(bus_if.busy_matriz), 0);
    tick(1);
    chk("single regrant", 32'(bus_if.gnt_matriz), 32'h1);
    set_st(0, 1'b0, 3, 5, 1'b0);
    tick(3);
    chk("single released", 32'(bus_if.gnt_matriz), 0);

    // Round-robin contention on the LEDs.
    set_st(0, 1'b1, 2, 1, 1'b1);
    set_st(1, 1'b1, 5, 7, 1'b1);
    tick(2);
    for (int i = 0; i < HOLD; i++) begin
      chk("rr first gnt", 32'(bus_if.gnt_leds), 32'h1);
      chk("rr first code", 32'(bus_if.fleds), 1);
      tick(1);
    end
    chk("rr gap", 32'(bus_if.gnt_leds), 0);
    tick(1);
    chk("rr second gnt", 32'(bus_if.gnt_leds), 32'h2);
    chk("rr second code", 32'(bus_if.fleds), 7);
    chk("rr second disp", 32'(bus_if.disp_id), 5);
    tick(HOLD);
    chk("rr gap2", 32'(bus_if.gnt_leds), 0);
    tick(1);
    chk("rr back to 0", 32'(bus_if.gnt_leds), 32'h1);
    chk("rr back disp", 32'(bus_if.disp_id), 2);
    set_st(0, 1'b0, 0, 0, 1'b0);
    set_st(1, 1'b0, 0, 0, 1'b0);
    tick(3);

    // Parallel terminals and early release.
    set_st(0, 1'b1, 4, 3, 1'b0);
    set_st(1, 1'b1, 6, 2, 1'b1);
    tick(2);
    chk("par gnt_matriz", 32'(bus_if.gnt_matriz), 32'h1);
    chk("par gnt_leds", 32'(bus_if.gnt_leds), 32'h2);
    chk("par disp_id", 32'(bus_if.disp_id), 4);
    chk("par fleds", 32'(bus_if.fleds), 2);
    tick(3);
    bus_if.req[1] = 1'b0;
    tick(1);
    chk("early still", 32'(bus_if.gnt_leds), 32'h2);
    tick(1);
    chk("early gnt_leds", 32'(bus_if.gnt_leds), 0);
    chk("early matrix on", 32'(bus_if.gnt_matriz), 32'h1);

    // Owner FUNC change is ignored while granted.
    set_st(0, 1'b1, 4, 6, 1'b0);
    tick(1);
    chk("stable fmatriz", 32'(bus_if.fmatriz), 3);
    chk("stable gnt", 32'(bus_if.gnt_matriz), 32'h1);

    // Asynchronous reset between edges, mid-grant.
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    #2 rst_n = 1'b1;
    set_st(0, 1'b1, 4, 6, 1'b0);
    set_st(1, 1'b1, 6, 2, 1'b0);
    tick(1);
    chk("post reset latency", 32'(bus_if.gnt_matriz), 0);
    tick(1);
    chk("post reset ptr", 32'(bus_if.gnt_matriz), 32'h1);
    chk("post reset code", 32'(bus_if.fmatriz), 6);
    chk("post reset disp", 32'(bus_if.disp_id), 4);
    tick(HOLD + 1);
    chk("post reset next", 32'(bus_if.gnt_matriz), 32'h2);
    chk("post reset next code", 32'(bus_if.fmatriz), 2);
    chk("post reset next disp", 32'(bus_if.disp_id), 6);
    bus_if.req = '0;
    tick(3);
    chk("final idle", 32'(bus_if.busy_matriz), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/controlador_acesso_rr.md
# controlador_acesso_rr

Sequential, parametrised access controller for N user stations competing for the two output terminals (matrix and LEDs). Each station presents an ID, a 3-bit functionality code and a target terminal. The block checks the ID/function pair against a permission mask and arbitrates each terminal round-robin. It holds a grant for a bounded number of cycles and reports the granted functionality code and the owner's ID for the 7-segment display path.

## Interface
- N_USERS, 2, number of user stations (≥2)
- ID_W, 3, authentication ID width
- HOLD_CYCLES, 8, maximum grant length in cycles (≥1)
- PERM_MASK, 64'hFEFE_FEFE_FEFE_FE00, bit [id*8+f] = 1 permits function f for ID id (default: ID 0 nothing, other IDs functions 1..7); width 2**ID_W*8
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ  in  N_USERS  request per station
- ID_IN  in  N_USERS*ID_W  station i ID at [i*ID_W +: ID_W]
- FUNC_IN  in  N_USERS*3  station i function code at [i*3 +: 3]; 0 = none
- TERM_IN  in  N_USERS  target terminal: 0 = matrix, 1 = LEDs
- GNT_MATRIZ  out  N_USERS  one-hot matrix owner
- GNT_LEDS  out  N_USERS  one-hot LED owner
- FMATRIZ  out  3  function code driven to matrix decoder
- FLEDS  out  3  function code driven to LED decoder
- BUSY_MATRIZ, BUSY_LEDS  out  1  terminal in GRANT
- DENY  out  N_USERS  request refused by permission
- DISP_ID  out  ID_W  ID of most recent grant
- DISP_VALID  out  1  DISP_ID meaningful

## Operation
- Input stage: REQ, ID_IN, FUNC_IN and TERM_IN are registered every cycle. All decisions use the registered copies.
- Station i is eligible for terminal t when all of the following hold: registered REQ[i]=1, FUNC≠0, PERM_MASK[ID*8+FUNC]=1, TERM=t.
- DENY[i] is registered, and is 1 exactly while REQ[i]=1, FUNC≠0 and the permission bit is 0. A denied station is never eligible.
- Each terminal has an independent two-state FSM, IDLE and GRANT.
  - IDLE: if any station is eligible, grant the first eligible index at or after the pointer, wrapping mod N_USERS. On grant:
    - latch the owner and its FUNC;
    - load the counter with HOLD_CYCLES-1;
    - set the pointer to owner+1 mod N_USERS;
    - go to GRANT.
  - GRANT: drive GNT one-hot and the latched code. Release when the registered REQ[owner]=0 or the counter reaches 0. Otherwise decrement the counter.
  - Release sets GNT to 0, the code to 0 and BUSY to 0, and returns the FSM to IDLE. Arbitration resumes the following cycle, giving exactly one idle cycle between grants.
- While a station owns a terminal, changes to its ID, FUNC or TERM are ignored until release.
- A station is eligible for only one terminal (its TERM). Both terminals may grant in the same cycle to different stations.
- DISP_ID and DISP_VALID:
  - on any grant, DISP_ID takes the owner's ID and DISP_VALID becomes 1;
  - if both terminals grant in the same cycle, the matrix owner's ID wins;
  - DISP_ID holds between grants.
- Reset state: every output is 0, both FSMs are IDLE, both pointers are 0, counters are 0 and input registers are 0.

## Timing
- Request latency: REQ and fields stable before edge k → input register at edge k → GNT, code and BUSY valid after edge k+1. DENY follows the same latency.
- Grant length: GNT is high for HOLD_CYCLES cycles if REQ is held. An early REQ drop before edge m clears GNT after edge m+1.
- Back-to-back grants on one terminal are separated by exactly one cycle with GNT=0.
- RST_N low asynchronously clears all state immediately, including mid-GRANT. After RST_N rises, the first grant needs the same two edges.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold RST_N=0 with random inputs. Required: all outputs 0. Release RST_N with REQ=0. Required: outputs stay 0.
- Single grant with timeout: station 0 with ID=3, FUNC=5, TERM=0, REQ held, defaults. Required: GNT_MATRIZ=2'b01, FMATRIZ=5, BUSY_MATRIZ=1, DISP_ID=3 two edges after the request. These hold for 8 cycles, then 1 cycle of all zeros, then a re-grant.
- Permission deny: station 1 with ID=0, FUNC=2, REQ=1. Required: DENY=2'b10 from the second edge, GNT_LEDS and GNT_MATRIZ stay 0, DISP_VALID=0.
- Round-robin contention: both stations assert REQ in the same cycle with TERM=1, IDs 2 and 5, FUNC 1 and 7. Required:
  - FLEDS=1 with GNT_LEDS=01 for 8 cycles;
  - then one idle cycle;
  - then GNT_LEDS=10 with FLEDS=7 and DISP_ID=5;
  - then station 0 again.
- Parallel terminals and early release:
  - Stimulus: station 0 on TERM=0 (ID 4, FUNC 3) and station 1 on TERM=1 (ID 6, FUNC 2), both asserted together.
  - Required: both granted on the same edge, DISP_ID=4.
  - Stimulus: drop REQ[1] after 3 cycles.
  - Required: GNT_LEDS=0 two edges later, while the matrix grant continues.
- Reset mid-grant and field stability:
  - Stimulus: during a grant, change the owner's FUNC.
  - Required: FMATRIZ unchanged.
  - Stimulus: pulse RST_N low asynchronously between clock edges.
  - Required: outputs 0 immediately, and the next grant goes to station 0 (pointer reset).
